seg7_scan_driver: RTL and testbench

- Downstream consumer of the BCD converter. Captures a 5-digit packed BCD word on the converter's ready pulse and time-multiplexes it onto a common-anode 7-segment display.
- Scans one digit per CLK_DIV cycles.
- New values are applied only at frame boundaries, so a frame never shows a mix of old and new digits.
- frame_o can drive the converter's en input to request the next conversion.

---
 rtl/seg7_pkg.sv | 18 +
 rtl/seg7_decoder.sv | 15 +
 rtl/seg7_scan_driver.sv | 116 +++++++++++
 tb/tb_seg7_scan_driver.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: active-high {g..a} patterns
// for every nibble value, the blank pattern and default sizing.
package seg7_pkg;

  localparam int unsigned DEFAULT_DIGITS  = 5;
  localparam int unsigned DEFAULT_CLK_DIV = 50000;

  localparam logic [6:0] SEG_OFF  = 7'h00;
  localparam logic [6:0] SEG_DASH = 7'h40;

  // Entry n is the pattern for nibble n; 10..15 render as a dash.
  localparam logic [15:0][6:0] SEG_TABLE = {
    SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH,
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg7_decoder.sv
// Nibble to active-high {g..a} segment pattern, flagging non-BCD values.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg,
  output logic       invalid
);

  always_comb begin
    seg     = SEG_TABLE[nibble];
    invalid = (nibble > 4'd9);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Captures packed BCD words on rdy_i and scans them onto a common-anode display,
// swapping words only at frame boundaries. SEG7_LZ_BLANK_EN enables leading-zero blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS         = DEFAULT_DIGITS,
  parameter int unsigned CLK_DIV        = DEFAULT_CLK_DIV,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4*DIGITS-1:0] data_i,
  input  logic                rdy_i,
  output logic [DIGITS-1:0]   an_o,
  output logic [6:0]          seg_o,
  output logic                frame_o,
  output logic                err_o
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned W     = 4 * DIGITS;

  logic [DIV_W-1:0]           div_q, div_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [W-1:0]               active_q, active_d, pend_q;
  logic                       pend_vld_q;
  logic                       div_wrap, boundary;
  logic [DIGITS-1:0][6:0]     dec_seg;
  logic [DIGITS-1:0]          dec_inv;
  logic [DIGITS-1:0]          blank;
  logic [DIGITS-1:0]          an_sel;
  logic [6:0]                 sel_seg;

  always_comb begin
    div_wrap = (div_q == DIV_W'(CLK_DIV - 1));
    boundary = div_wrap && (idx_q == IDX_W'(DIGITS - 1));
    div_d    = div_wrap ? '0 : div_q + 1'b1;
    idx_d    = idx_q;
    if (div_wrap) begin
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
    active_d = active_q;
    if (boundary) begin
      if (rdy_i) begin
        active_d = data_i;
      end else if (pend_vld_q) begin
        active_d = pend_q;
      end
    end
  end

  // Outputs are decoded from next-cycle state so the new word's digit 0 lines up with frame_o.
  for (genvar k = 0; k < DIGITS; k++) begin : g_dec
    seg7_decoder u_dec (
      .nibble  (active_d[4*k +: 4]),
      .seg     (dec_seg[k]),
      .invalid (dec_inv[k])
    );
  end

`ifdef SEG7_LZ_BLANK_EN
  logic lz_seen;

  always_comb begin
    blank   = '0;
    lz_seen = 1'b0;
    for (int unsigned k = DIGITS - 1; k >= 1; k--) begin
      lz_seen  = lz_seen | (active_d[4*k +: 4] != 4'd0);
      blank[k] = ~lz_seen;
    end
  end
`else
  always_comb begin
    blank = '0;
  end
`endif

  always_comb begin
    an_sel        = '0;
    an_sel[idx_d] = 1'b1;
    sel_seg       = blank[idx_d] ? SEG_OFF : dec_seg[idx_d];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q      <= '0;
      idx_q      <= '0;
      active_q   <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      an_o       <= AN_ACTIVE_LOW ? '1 : '0;
      seg_o      <= SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
      frame_o    <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      div_q    <= div_d;
      idx_q    <= idx_d;
      active_q <= active_d;
      if (boundary) begin
        pend_vld_q <= 1'b0;
      end else if (rdy_i) begin
        pend_q     <= data_i;
        pend_vld_q <= 1'b1;
      end
      an_o    <= AN_ACTIVE_LOW ? ~an_sel : an_sel;
      seg_o   <= SEG_ACTIVE_LOW ? ~sel_seg : sel_seg;
      frame_o <= boundary;
      if (boundary) begin
        err_o <= |dec_inv;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver (5 digits, 4 cycles per digit, active-low outputs):
// frame-position model checked every cycle plus literal display expectations.
module tb_seg7_scan_driver;

  localparam int ND    = 5;
  localparam int NDIV  = 4;
  localparam int FRAME = ND * NDIV;

  localparam logic [6:0] PAT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40
  };

`ifdef SEG7_LZ_BLANK_EN
  localparam logic [6:0] LZ_SEG = 7'h7F;
`else
  localparam logic [6:0] LZ_SEG = 7'h40;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy_i = 1'b0;
  logic [19:0] data_i = '0;
  logic [4:0]  an_o;
  logic [6:0]  seg_o;
  logic        frame_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .DIGITS         (ND),
    .CLK_DIV        (NDIV),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .data_i  (data_i),
    .rdy_i   (rdy_i),
    .an_o    (an_o),
    .seg_o   (seg_o),
    .frame_o (frame_o),
    .err_o   (err_o)
  );

  // Model: cycles since reset release, the word on display, newest word received this frame.
  int          cyc = 0;
  bit          rs = 1'b0;
  bit          started = 1'b0;
  logic [19:0] shown = '0;
  logic [19:0] newest = '0;
  bit          have_new = 1'b0;

  always @(posedge clk) begin
    started <= 1'b1;
    if (rst) begin
      cyc      <= 0;
      rs       <= 1'b1;
      shown    <= '0;
      have_new <= 1'b0;
    end else begin
      rs <= 1'b0;
      if (cyc % FRAME == FRAME - 1) begin
        if (rdy_i) shown <= data_i;
        else if (have_new) shown <= newest;
        have_new <= 1'b0;
      end else if (rdy_i) begin
        newest   <= data_i;
        have_new <= 1'b1;
      end
      cyc <= cyc + 1;
    end
  end

  function automatic logic [6:0] exp_seg(input logic [19:0] w, input int k);
    logic [3:0] n;
    n = w[4*k +: 4];
`ifdef SEG7_LZ_BLANK_EN
    if (k > 0 && (w >> (4 * k)) == 20'h0) return 7'h7F;
`endif
    return ~PAT[n];
  endfunction

  function automatic bit any_bad(input logic [19:0] w);
    for (int k = 0; k < ND; k++) begin
      if (w[4*k +: 4] > 4'd9) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pin(input string name, input logic [4:0] ean, input logic [6:0] eseg);
    chk({name, "_an"}, 32'(an_o), 32'(ean));
    chk({name, "_seg"}, 32'(seg_o), 32'(eseg));
  endtask

  always @(negedge clk) begin
    if (started) begin
      if (rs || cyc == 0) begin
        chk("rst_an", 32'(an_o), 32'h1F);
        chk("rst_seg", 32'(seg_o), 32'h7F);
        chk("rst_frame", 32'(frame_o), 32'h0);
        chk("rst_err", 32'(err_o), 32'h0);
      end else begin
        int k;
        logic [4:0] ean;
        k   = (cyc / NDIV) % ND;
        ean = ~(5'b00001 << k);
        chk("model_an", 32'(an_o), 32'(ean));
        chk("model_seg", 32'(seg_o), 32'(exp_seg(shown, k)));
        chk("model_frame", 32'(frame_o), 32'(cyc % FRAME == 0));
        chk("model_err", 32'(err_o), 32'(any_bad(shown)));
      end
    end
  end

  task automatic goto_pos(input int p);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cyc % FRAME != p && n < 3 * FRAME);
    if (cyc % FRAME != p) begin
      checks++;
      errors++;
      $display("FAIL goto_pos: position %0d required %0d", cyc % FRAME, p);
    end
  endtask

  task automatic pulse(input logic [19:0] d);
    rdy_i  = 1'b1;
    data_i = d;
    @(negedge clk);
    rdy_i  = 1'b0;
    data_i = 20'($urandom);
  endtask

  function automatic logic [19:0] rand_word();
    logic [19:0] w;
    int z;
    for (int k = 0; k < ND; k++) begin
      int r;
      r = int'($urandom_range(0, 11));
      w[4*k +: 4] = (r < 10) ? 4'(r) : 4'($urandom_range(10, 15));
    end
    z = int'($urandom_range(0, 4));
    for (int k = ND - z; k < ND; k++) w[4*k +: 4] = 4'h0;
    return w;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pin("first_digit", 5'b11110, 7'h40);

    goto_pos(8);
    pulse(20'h12345);
    pin("pre_update", 5'b11011, 7'h40);
    goto_pos(0);
    chk("frame_pulse", 32'(frame_o), 32'h1);
    goto_pos(9);
    pin("d2_of_12345", 5'b11011, 7'h30);
    goto_pos(17);
    pin("d4_of_12345", 5'b01111, 7'h79);

    goto_pos(3);
    pulse(20'h11111);
    goto_pos(10);
    pulse(20'h00042);
    goto_pos(1);
    pin("overwrite_d0", 5'b11110, 7'h24);
    goto_pos(5);
    pin("overwrite_d1", 5'b11101, 7'h19);
    goto_pos(19);
    pulse(20'h77777);
    pin("boundary_rdy_d0", 5'b11110, 7'h78);

    goto_pos(5);
    pulse(20'h0A009);
    goto_pos(0);
    chk("err_set", 32'(err_o), 32'h1);
    pin("inv_d0", 5'b11110, 7'h10);
    goto_pos(13);
    pin("inv_d3_dash", 5'b10111, 7'h3F);
    goto_pos(18);
    chk("err_held", 32'(err_o), 32'h1);
    goto_pos(2);
    pulse(20'h00009);
    goto_pos(19);
    chk("err_until_boundary", 32'(err_o), 32'h1);
    goto_pos(0);
    chk("err_clear", 32'(err_o), 32'h0);

    goto_pos(4);
    pulse(20'h00042);
    goto_pos(1);
    pin("lz_d0", 5'b11110, 7'h24);
    goto_pos(5);
    pin("lz_d1", 5'b11101, 7'h19);
    goto_pos(9);
    pin("lz_d2", 5'b11011, LZ_SEG);
    goto_pos(17);
    pin("lz_d4", 5'b01111, LZ_SEG);
    goto_pos(18);
    pulse(20'h00000);
    goto_pos(1);
    pin("zero_d0", 5'b11110, 7'h40);
    goto_pos(5);
    pin("zero_d1", 5'b11101, LZ_SEG);

    for (int i = 0; i < 30 * FRAME; i++) begin
      rdy_i  = ($urandom_range(0, 5) == 0);
      data_i = rand_word();
      @(negedge clk);
    end
    rdy_i = 1'b0;

    goto_pos(6);
    pulse(20'h98765);
    goto_pos(12);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pin("rerst_first", 5'b11110, 7'h40);
    goto_pos(1);
    pin("rerst_d0", 5'b11110, 7'h40);
    goto_pos(1);
    pin("rerst_d0_next", 5'b11110, 7'h40);
    goto_pos(17);
    pin("rerst_d4", 5'b01111, LZ_SEG);
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
